// File: rtl/tt_adder_selftest.sv
// On-chip exhaustive stimulus generator and checker for TinyTapeout adders.
// Sweeps every operand pair, compares each result against a+b, and records the outcome.
module tt_adder_selftest #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] drv_ui,
  input  logic [7:0] mon_uo,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [7:0] fail_vec
);

  localparam int VW = 2 * WIDTH;
  localparam logic [VW-1:0] VEC_LAST = '1;
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t state_q, state_d;
  logic [VW-1:0] vec_q, vec_d;
  logic [3:0] settle_q, settle_d;
  logic [7:0] drv_ui_q, drv_ui_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic pass_q, pass_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [7:0] fail_vec_q, fail_vec_d;

  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0] expected_sum;
  logic mismatch;
  logic unused_mon;

  function automatic logic [7:0] pattern(input logic [VW-1:0] v);
    return 8'(v);
  endfunction

  assign op_a = vec_q[WIDTH-1:0];
  assign op_b = vec_q[VW-1:WIDTH];
  assign expected_sum = {1'b0, op_a} + {1'b0, op_b};
  assign mismatch = (mon_uo[WIDTH:0] != expected_sum);
  // Result bits above WIDTH are outside the adder's output and never checked.
  assign unused_mon = ^mon_uo;

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    settle_d   = settle_q;
    drv_ui_d   = drv_ui_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_cnt_d  = err_cnt_q;
    fail_vec_d = fail_vec_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_SETTLE;
          vec_d      = '0;
          drv_ui_d   = pattern('0);
          err_cnt_d  = '0;
          fail_vec_d = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
          settle_d   = SETTLE_INIT;
        end
      end
      ST_SETTLE: begin
        settle_d = settle_q - 4'd1;
        if (settle_q == 4'd1) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (mismatch) begin
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          if (err_cnt_q == 8'd0) fail_vec_d = drv_ui_q;
        end
        if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == 8'd0);
        end else begin
          state_d  = ST_SETTLE;
          vec_d    = vec_q + 1'b1;
          drv_ui_d = pattern(vec_q + 1'b1);
          settle_d = SETTLE_INIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      settle_q   <= '0;
      drv_ui_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      fail_vec_q <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      settle_q   <= settle_d;
      drv_ui_q   <= drv_ui_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      fail_vec_q <= fail_vec_d;
    end
  end

  assign drv_ui   = drv_ui_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign fail_vec = fail_vec_q;

endmodule

// File: doc/tt_adder_selftest.md
Name: tt_adder_selftest

Overview:
- On-chip stimulus generator and self-checker for the team's TinyTapeout adder designs (half adder at WIDTH=1, ripple adders at larger WIDTH).
- Drives the DUT's dedicated-input bus and samples its dedicated-output bus.
- Sweeps every operand pair exhaustively and compares each DUT result against a+b.
- Reports pass/fail, a saturating error count and the first failing vector, giving a standalone harness that needs no external bench.

Parameters:
- WIDTH, 1, operand width in bits per operand; legal range 1..4 so that 2*WIDTH <= 8.
- SETTLE, 2, cycles each vector is held before the result is sampled; legal range 1..15.

Ports:
- clk  input  1  single clock; all state is on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  one-cycle request to run a full sweep.
- drv_ui  output  8  stimulus bus to the DUT's ui_in.
- mon_uo  input  8  DUT's uo_out, sampled as the result.
- busy  output  1  high while a sweep is running.
- done  output  1  high after a sweep completes; held until the next accepted start.
- pass  output  1  valid when done=1; 1 means zero mismatches.
- err_cnt  output  8  mismatch count, saturating at 255.
- fail_vec  output  8  drv_ui value of the first mismatching vector; 0 if there was none.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; drv_ui, busy, done, pass, err_cnt, fail_vec all 0; vector counter and settle counter are 0.
- Asserting reset mid-sweep aborts the sweep immediately. Nothing resumes after release.
- Vector encoding:
  - vec is a 2*WIDTH-bit counter.
  - a = vec[WIDTH-1:0], b = vec[2*WIDTH-1:WIDTH].
  - drv_ui = {zero-pad, b, a}.
  - Expected result = a+b, WIDTH+1 bits, compared with mon_uo[WIDTH:0].
  - mon_uo[7:WIDTH+1] is ignored.
  - At WIDTH=1: mon_uo[0]=sum, mon_uo[1]=carry.
- Number of vectors N = 2^(2*WIDTH).
- IDLE / DONE:
  - start=1 moves to SETTLE.
  - On that edge: vec=0, drv_ui=pattern(0), err_cnt=0, fail_vec=0, done=0, pass=0, busy=1, settle counter=SETTLE.
  - start=0 leaves the state unchanged.
- SETTLE:
  - Settle counter decrements each cycle.
  - When it reaches 1, the next state is CHECK.
  - The state lasts exactly SETTLE cycles per vector.
- CHECK (one cycle):
  - Sample mon_uo and compare.
  - On mismatch: err_cnt increments unless it is already 255; if err_cnt was 0, fail_vec=drv_ui.
  - If vec = N-1: go to DONE with busy=0, done=1, and pass=1 iff the final error count is 0 (including this cycle's compare).
  - Otherwise: vec+1, drv_ui=pattern(vec+1), settle counter=SETTLE, go to SETTLE.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - done rises exactly N*(SETTLE+1) cycles after the edge that accepts start.
  - At defaults that is 12 cycles.
- start while busy=1 is ignored, with no restart and no effect on counters.
- start in DONE restarts the sweep, clearing done, pass and the counters on the accepting edge.
- drv_ui keeps the last vector after DONE, until restart or reset.
- vec wrap-around is never reached: the sweep terminates at N-1.
- err_cnt saturates at 255 and does not wrap. This is reachable at WIDTH=4, where N=256.
- Simultaneous start and rst: reset wins.

Test Plan:
- Correct half adder (WIDTH=1, SETTLE=2), pulse start → busy=1 for 12 cycles; drv_ui steps 0x00,0x01,0x02,0x03; done=1, pass=1, err_cnt=0, fail_vec=0x00.
- DUT model with carry stuck at 0 (WIDTH=1) → mismatch only at a=1,b=1; err_cnt=1, fail_vec=0x03, pass=0.
- DUT model with sum inverted (WIDTH=1) → all 4 vectors mismatch; err_cnt=4, fail_vec=0x00, pass=0.
- WIDTH=4, SETTLE=1, mon_uo tied to 0xFF → every vector mismatches; err_cnt saturates at 255 and stays 255; fail_vec=0x00; done after 512 cycles.
- start pulsed again while busy, then again after done → first re-pulse ignored (done timing unchanged); second restarts with err_cnt and fail_vec cleared on the accepting edge.
- rst asserted during the 3rd vector's SETTLE → all outputs 0 immediately (asynchronous), state IDLE; no further drv_ui changes until the next start.
